mem_port_scheduler: RTL and testbench
=====================================

# mem_port_scheduler

Schedules access to the shared 16-bit cellram between 4 write channels (FIFO→RAM, sources EP2/ADC) and 4 read channels (RAM→FIFO, sinks DAC/EP6). Each channel index owns one ring-buffer region in cellram. The block round-robins over the 8 slots, sizes each burst from FIFO occupancy and ring fill, and hands a grant (direction, port, word address, length) to the memory transfer engine. It updates ring pointers when the engine reports completion.

## Interface
- NUM_PORTS, 4: channels per direction; slots = 2*NUM_PORTS.
- FIFO_AW, 11: width of FIFO level/space fields.
- MEM_AW, 23: cellram word address width.
- REGION_AW, 20: per-port ring size is 2^REGION_AW words.
- MAX_BURST, 64: maximum words per grant.

Ports:
- clk  in  1  scheduler clock (memory clock domain).
- reset  in  1  synchronous, active-high.
- wr_level  in  NUM_PORTS*FIFO_AW  bytes readable in each write-side FIFO.
- rd_space  in  NUM_PORTS*FIFO_AW  bytes free in each read-side FIFO.
- flush  in  NUM_PORTS  per-port ring clear request, 1-cycle pulse.
- grant_valid  out  1  grant offered.
- grant_ready  in  1  engine accepts grant.
- grant_dir  out  1  1 = write RAM, 0 = read RAM.
- grant_port  out  clog2(NUM_PORTS)  channel index.
- grant_addr  out  MEM_AW  start word address = port*2^REGION_AW + ptr.
- grant_len  out  clog2(MAX_BURST)+1  words, 1..MAX_BURST.
- done  in  1  1-cycle pulse, engine finished the accepted burst.
- fill  out  NUM_PORTS*(REGION_AW+1)  words stored per ring.
- stat_words  out  2*NUM_PORTS*32  per-slot granted-word counters (see Configuration).

## Operation
- Slot encoding: slots 0..NUM_PORTS-1 are writes to ports 0..N-1; slots N..2N-1 are reads from ports 0..N-1.
- Per port, the block tracks wr_ptr and rd_ptr (REGION_AW bits) and fill (REGION_AW+1 bits).
- Write slot length is min(wr_level>>1, MAX_BURST, 2^REGION_AW - fill). An odd trailing byte waits.
- Read slot length is min(fill, rd_space>>1, MAX_BURST).
- A slot is eligible when its length ≥ 1.
- FSM states:
  - SCAN: evaluate slot rr_ptr and register its length. If eligible, go to GRANT; otherwise rr_ptr = rr_ptr+1 mod 2N and stay in SCAN.
  - GRANT: grant_valid=1. All grant_* fields are held stable until a clock edge with grant_valid & grant_ready, then go to BUSY.
  - BUSY: wait for done.
    - Write: wr_ptr += len (mod 2^REGION_AW), fill += len.
    - Read: rd_ptr += len, fill -= len.
    - Then rr_ptr = granted slot + 1, go to SCAN.
- Pointer wrap: a burst never splits at the region end. The engine increments only the low REGION_AW bits of the address, so a burst wraps inside its region.
- done outside BUSY is ignored. grant_ready outside GRANT is ignored.
- Flush of port p clears wr_ptr, rd_ptr and fill.
  - If port p is granted/BUSY, the flush is held pending and applied on the cycle done is processed, overriding that update (result 0).
  - Flushes of other ports apply immediately.
- Simultaneous flush and SCAN evaluation of the same port: the flush wins and the slot is evaluated ineligible that cycle.

## Timing
- Reset values: grant_valid=0, grant_dir=0, grant_port=0, grant_addr=0, grant_len=0, all pointers/fill=0, rr_ptr=0, stat_words=0, state SCAN.
- Reset mid-burst abandons the grant. grant_valid is low on the cycle after the reset edge.
- Eligible slot scanned in cycle t → grant_valid high in cycle t+1.
- done in cycle t → fill updated at t+1, and SCAN resumes at t+1. The next grant comes no earlier than t+2.
- Full scan with nothing eligible: 2N cycles, repeating.
- Inputs wr_level/rd_space are sampled only in SCAN.

## Configuration
- MEM_PORT_SCHED_STATS_EN defined: one 32-bit counter per slot, incremented by grant_len at each accepted grant, saturating at 2^32-1, cleared only by reset.
- Not defined: counters are not built and stat_words is tied to 0.

## Structure
- Package mem_sched_pkg holds:
  - DIR_READ/DIR_WRITE constants.
  - FSM state enum (SCAN, GRANT, BUSY).
  - Slot-to-port/direction helper functions.
  - Defaults for MAX_BURST and REGION_AW.
- Sub-module mem_sched_region is instantiated per port. It holds wr_ptr, rd_ptr, fill, pending flush and the length computation.

## Test plan
- After reset, wr_level[0]=200, grant_ready=1 → grant dir=1, port=0, addr=0, len=64. After done, fill[0]=64.
- Then rd_space[0]=20, wr_level=0 → read grant port=0, addr=0, len=10. After done, fill[0]=54 and rd_ptr=10.
- wr_level=2 on all 4 write ports, grant_ready=1 → grants in port order 0,1,2,3, each len=1. Round-robin resumes at slot 4.
- Ring wrap with REGION_AW=4: wr_ptr=14, fill=0, wr_level=16 → grant_addr=14, len=8, then wr_ptr=6. With fill=16, no write grant is issued.
- flush[1] pulsed while port 1 is BUSY → after done, fill[1]=0 and its pointers=0. Port 0 fill is unchanged.
- With MEM_PORT_SCHED_STATS_EN, three grants of len 64 on slot 0 → stat_words[31:0]=192. Without the macro, stat_words=0.

Source files
------------

// File: rtl/mem_sched_pkg.sv
// Shared definitions for the cellram port scheduler.
//   - DIR_READ / DIR_WRITE : grant direction encoding (1 = FIFO->RAM write).
//   - state_t              : scheduler FSM states (SCAN, GRANT, BUSY).
//   - slot_dir / slot_port : map a round-robin slot index to direction/port.
//   - min3                 : burst length clamp helper.
//   - DEF_MAX_BURST / DEF_REGION_AW : default burst cap and ring size.
package mem_sched_pkg;

   localparam logic DIR_READ  = 1'b0;
   localparam logic DIR_WRITE = 1'b1;

   localparam int DEF_MAX_BURST = 64;
   localparam int DEF_REGION_AW = 20;

   typedef enum logic [1:0] {SCAN, GRANT, BUSY} state_t;

   // Slots 0..N-1 are writes to ports 0..N-1, slots N..2N-1 are reads.
   function automatic logic slot_dir(input int slot, input int num_ports);
      return (slot < num_ports) ? DIR_WRITE : DIR_READ;
   endfunction

   function automatic int slot_port(input int slot, input int num_ports);
      return (slot < num_ports) ? slot : slot - num_ports;
   endfunction

   function automatic int unsigned min3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b < m) m = b;
      if (c < m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/mem_sched_region.sv
// Ring-buffer bookkeeping for one channel index.
// Holds wr_ptr, rd_ptr, fill and a pending-flush flag, and computes the
// candidate burst length for the write and read slots of this port.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   wr_level, rd_space      : write-FIFO bytes readable / read-FIFO bytes free
//   flush                   : ring clear request (1-cycle pulse)
//   owned                   : this port holds the current grant (GRANT/BUSY)
//   update, update_dir/len  : completion of the owned burst
//   wr_ptr, rd_ptr, fill    : ring state
//   wr_len, rd_len          : candidate burst lengths (0 = not eligible)
module mem_sched_region
   import mem_sched_pkg::*;
#(
   parameter int FIFO_AW   = 11,
   parameter int REGION_AW = DEF_REGION_AW,
   parameter int MAX_BURST = DEF_MAX_BURST,
   parameter int LEN_W     = $clog2(MAX_BURST) + 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [FIFO_AW-1:0]   wr_level,
   input  logic [FIFO_AW-1:0]   rd_space,
   input  logic                 flush,
   input  logic                 owned,
   input  logic                 update,
   input  logic                 update_dir,
   input  logic [LEN_W-1:0]     update_len,
   output logic [REGION_AW-1:0] wr_ptr,
   output logic [REGION_AW-1:0] rd_ptr,
   output logic [REGION_AW:0]   fill,
   output logic [LEN_W-1:0]     wr_len,
   output logic [LEN_W-1:0]     rd_len
);

   localparam int unsigned RING = 2 ** REGION_AW;

   logic        pending;
   int unsigned wr_room;
   int unsigned wr_words;
   int unsigned rd_words;

   // FIFO counts are in bytes; an odd trailing byte is left for later.
   always_comb begin
      wr_room  = RING - 32'(fill);
      wr_words = 32'(wr_level >> 1);
      rd_words = 32'(rd_space >> 1);
      wr_len   = LEN_W'(min3(wr_words, MAX_BURST, wr_room));
      rd_len   = LEN_W'(min3(32'(fill), rd_words, MAX_BURST));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         fill    <= '0;
         pending <= 1'b0;
      end else if (update) begin
         // A flush seen during the burst overrides the completion update.
         if (pending || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            fill    <= '0;
            pending <= 1'b0;
         end else if (update_dir == DIR_WRITE) begin
            wr_ptr <= wr_ptr + REGION_AW'(update_len);
            fill   <= fill + (REGION_AW + 1)'(update_len);
         end else begin
            rd_ptr <= rd_ptr + REGION_AW'(update_len);
            fill   <= fill - (REGION_AW + 1)'(update_len);
         end
      end else if (flush) begin
         if (owned) begin
            pending <= 1'b1;
         end else begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
         end
      end
   end

endmodule

// File: rtl/mem_port_scheduler.sv
// Round-robin scheduler for the shared 16-bit cellram.
// Visits 2*NUM_PORTS slots (writes first, then reads), sizes each burst from
// FIFO occupancy and ring fill, offers a grant to the transfer engine and
// advances the ring pointers on completion.
// Optional feature: define MEM_PORT_SCHED_STATS_EN to build per-slot
// saturating 32-bit granted-word counters; otherwise stat_words is 0.
// Ports:
//   clk, reset       : memory clock, synchronous active-high reset
//   wr_level         : per-port bytes readable in write-side FIFOs
//   rd_space         : per-port bytes free in read-side FIFOs
//   flush            : per-port ring clear pulse
//   grant_*          : grant handshake (dir 1 = write RAM) and burst fields
//   done             : engine finished the accepted burst
//   fill             : words stored per ring
//   stat_words       : per-slot granted-word counters
module mem_port_scheduler
   import mem_sched_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int FIFO_AW   = 11,
   parameter int MEM_AW    = 23,
   parameter int REGION_AW = DEF_REGION_AW,
   parameter int MAX_BURST = DEF_MAX_BURST
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [NUM_PORTS*FIFO_AW-1:0]          wr_level,
   input  logic [NUM_PORTS*FIFO_AW-1:0]          rd_space,
   input  logic [NUM_PORTS-1:0]                  flush,
   output logic                                  grant_valid,
   input  logic                                  grant_ready,
   output logic                                  grant_dir,
   output logic [$clog2(NUM_PORTS)-1:0]          grant_port,
   output logic [MEM_AW-1:0]                     grant_addr,
   output logic [$clog2(MAX_BURST):0]            grant_len,
   input  logic                                  done,
   output logic [NUM_PORTS*(REGION_AW+1)-1:0]    fill,
   output logic [2*NUM_PORTS*32-1:0]             stat_words
);

   localparam int PORT_W = $clog2(NUM_PORTS);
   localparam int SLOT_W = $clog2(2 * NUM_PORTS);
   localparam int LEN_W  = $clog2(MAX_BURST) + 1;

   state_t                state;
   logic [SLOT_W-1:0]     rr_ptr;
   logic [LEN_W-1:0]      wr_len [NUM_PORTS];
   logic [LEN_W-1:0]      rd_len [NUM_PORTS];
   logic [REGION_AW-1:0]  wr_ptr [NUM_PORTS];
   logic [REGION_AW-1:0]  rd_ptr [NUM_PORTS];
   logic [NUM_PORTS-1:0]  owned;
   logic                  update;
   logic                  scan_dir;
   logic [PORT_W-1:0]     scan_port;
   logic [LEN_W-1:0]      scan_len;
   logic [REGION_AW-1:0]  scan_ptr;

   function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] s);
      return (s == SLOT_W'(2 * NUM_PORTS - 1)) ? '0 : s + 1'b1;
   endfunction

   assign update = (state == BUSY) && done;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_region
      assign owned[p] = (state != SCAN) && (grant_port == PORT_W'(p));

      mem_sched_region #(
         .FIFO_AW   (FIFO_AW),
         .REGION_AW (REGION_AW),
         .MAX_BURST (MAX_BURST),
         .LEN_W     (LEN_W)
      ) u_region (
         .clk        (clk),
         .reset      (reset),
         .wr_level   (wr_level[p*FIFO_AW +: FIFO_AW]),
         .rd_space   (rd_space[p*FIFO_AW +: FIFO_AW]),
         .flush      (flush[p]),
         .owned      (owned[p]),
         .update     (update && owned[p]),
         .update_dir (grant_dir),
         .update_len (grant_len),
         .wr_ptr     (wr_ptr[p]),
         .rd_ptr     (rd_ptr[p]),
         .fill       (fill[p*(REGION_AW+1) +: REGION_AW+1]),
         .wr_len     (wr_len[p]),
         .rd_len     (rd_len[p])
      );
   end

   // A flush landing on the scanned port wins: that slot is ineligible.
   always_comb begin
      scan_dir  = slot_dir(int'(rr_ptr), NUM_PORTS);
      scan_port = PORT_W'(slot_port(int'(rr_ptr), NUM_PORTS));
      if (scan_dir == DIR_WRITE) begin
         scan_len = wr_len[scan_port];
         scan_ptr = wr_ptr[scan_port];
      end else begin
         scan_len = rd_len[scan_port];
         scan_ptr = rd_ptr[scan_port];
      end
      if (flush[scan_port]) scan_len = '0;
   end

   // rr_ptr stays on the granted slot through GRANT/BUSY, so the resume
   // point after done is simply its successor.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= SCAN;
         rr_ptr      <= '0;
         grant_valid <= 1'b0;
         grant_dir   <= DIR_READ;
         grant_port  <= '0;
         grant_addr  <= '0;
         grant_len   <= '0;
      end else begin
         case (state)
            SCAN: begin
               if (scan_len != '0) begin
                  state       <= GRANT;
                  grant_valid <= 1'b1;
                  grant_dir   <= scan_dir;
                  grant_port  <= scan_port;
                  grant_addr  <= (MEM_AW'(scan_port) << REGION_AW) | MEM_AW'(scan_ptr);
                  grant_len   <= scan_len;
               end else begin
                  rr_ptr <= next_slot(rr_ptr);
               end
            end
            GRANT: begin
               if (grant_ready) begin
                  grant_valid <= 1'b0;
                  state       <= BUSY;
               end
            end
            BUSY: begin
               if (done) begin
                  state  <= SCAN;
                  rr_ptr <= next_slot(rr_ptr);
               end
            end
            default: state <= SCAN;
         endcase
      end
   end

`ifdef MEM_PORT_SCHED_STATS_EN
   logic [31:0] stat_cnt [2*NUM_PORTS];
   logic [32:0] stat_sum;

   assign stat_sum = {1'b0, stat_cnt[rr_ptr]} + 33'(grant_len);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < 2 * NUM_PORTS; s++) stat_cnt[s] <= '0;
      end else if (state == GRANT && grant_ready) begin
         stat_cnt[rr_ptr] <= stat_sum[32] ? '1 : stat_sum[31:0];
      end
   end

   for (genvar s = 0; s < 2 * NUM_PORTS; s++) begin : g_stat
      assign stat_words[s*32 +: 32] = stat_cnt[s];
   end
`else
   assign stat_words = '0;
`endif

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Self-checking bench for mem_port_scheduler: a default-size instance and a
// small-ring instance (REGION_AW=4) for pointer wrap and full-ring checks.
module tb_mem_port_scheduler;

   localparam int N    = 4;
   localparam int FAW  = 11;
   localparam int MAW  = 23;
   localparam int RAW  = 20;
   localparam int WRAW = 4;
   localparam int LW   = 7;

   typedef struct packed {
      logic           dir;
      logic [1:0]     port;
      logic [MAW-1:0] addr;
      logic [LW-1:0]  len;
   } grant_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [N*FAW-1:0]      wr_level, rd_space, w_wr_level, w_rd_space;
   logic [N-1:0]          flush, w_flush;
   logic                  grant_ready, done, w_done;
   logic                  grant_valid, grant_dir, w_grant_valid, w_grant_dir;
   logic [1:0]            grant_port, w_grant_port;
   logic [MAW-1:0]        grant_addr, w_grant_addr;
   logic [LW-1:0]         grant_len, w_grant_len;
   logic [N*(RAW+1)-1:0]  fill;
   logic [N*(WRAW+1)-1:0] w_fill;
   logic [2*N*32-1:0]     stat_words, w_stat_words;

   grant_t q0[$];
   grant_t q1[$];
   longint exp_stat [2*N];
   int     compared   = 0;
   int     mismatched = 0;

   mem_port_scheduler dut (
      .clk(clk), .reset(reset), .wr_level(wr_level), .rd_space(rd_space),
      .flush(flush), .grant_valid(grant_valid), .grant_ready(grant_ready),
      .grant_dir(grant_dir), .grant_port(grant_port), .grant_addr(grant_addr),
      .grant_len(grant_len), .done(done), .fill(fill), .stat_words(stat_words)
   );

   mem_port_scheduler #(.REGION_AW(WRAW)) dut_w (
      .clk(clk), .reset(reset), .wr_level(w_wr_level), .rd_space(w_rd_space),
      .flush(w_flush), .grant_valid(w_grant_valid), .grant_ready(grant_ready),
      .grant_dir(w_grant_dir), .grant_port(w_grant_port), .grant_addr(w_grant_addr),
      .grant_len(w_grant_len), .done(w_done), .fill(w_fill), .stat_words(w_stat_words)
   );

   function automatic longint fill0(input int p);
      return longint'(fill[p*(RAW+1) +: RAW+1]);
   endfunction

   function automatic longint fillw(input int p);
      return longint'(w_fill[p*(WRAW+1) +: WRAW+1]);
   endfunction

   task automatic check(input string name, input longint act, input longint req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic expect_grant(input int inst, input logic dir, input int port,
                               input longint addr, input int len);
      grant_t g;
      g.dir  = dir;
      g.port = 2'(port);
      g.addr = MAW'(addr);
      g.len  = LW'(len);
      if (inst == 0) begin
         q0.push_back(g);
         exp_stat[dir ? port : N + port] += len;
      end else begin
         q1.push_back(g);
      end
   endtask

   task automatic mon_compare(input string tag, input grant_t e, input grant_t a);
      compared++;
      if (a !== e) begin
         mismatched++;
         $display("FAIL %s actual dir=%0d port=%0d addr=%0h len=%0d required dir=%0d port=%0d addr=%0h len=%0d",
                  tag, a.dir, a.port, a.addr, a.len, e.dir, e.port, e.addr, e.len);
      end
   endtask

   // Monitors: compare each accepted grant against the scoreboard queue.
   always @(negedge clk) begin
      if (!reset && grant_valid && grant_ready) begin
         if (q0.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL grant0_unexpected actual port=%0d addr=%0h required=none", grant_port, grant_addr);
         end else begin
            mon_compare("grant0", q0.pop_front(), {grant_dir, grant_port, grant_addr, grant_len});
         end
      end
   end

   always @(negedge clk) begin
      if (!reset && w_grant_valid && grant_ready) begin
         if (q1.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL grantw_unexpected actual port=%0d addr=%0h required=none", w_grant_port, w_grant_addr);
         end else begin
            mon_compare("grantw", q1.pop_front(), {w_grant_dir, w_grant_port, w_grant_addr, w_grant_len});
         end
      end
   end

   // Engine model: wait for a grant, accept it, drop that channel's
   // occupancy, optionally pulse flush while busy, then pulse done.
   task automatic serve(input int inst, input logic [N-1:0] fl);
      int   n = 0;
      logic gv, gd;
      int   gp;
      do begin
         @(negedge clk);
         n++;
         gv = (inst == 0) ? grant_valid : w_grant_valid;
      end while (!gv && n < 100);
      if (!gv) begin
         compared++; mismatched++;
         $display("FAIL serve_timeout inst=%0d actual=no_grant required=grant", inst);
         return;
      end
      gd = (inst == 0) ? grant_dir : w_grant_dir;
      gp = (inst == 0) ? int'(grant_port) : int'(w_grant_port);
      @(negedge clk);
      if (inst == 0) begin
         if (gd) wr_level[gp*FAW +: FAW] = '0; else rd_space[gp*FAW +: FAW] = '0;
         flush = fl;
      end else begin
         if (gd) w_wr_level[gp*FAW +: FAW] = '0; else w_rd_space[gp*FAW +: FAW] = '0;
         w_flush = fl;
      end
      @(negedge clk);
      flush = '0; w_flush = '0;
      if (inst == 0) done = 1'b1; else w_done = 1'b1;
      @(negedge clk);
      done = 1'b0; w_done = 1'b0;
   endtask

   initial begin
      int seen;
      reset = 1'b1;
      wr_level = '0; rd_space = '0; w_wr_level = '0; w_rd_space = '0;
      flush = '0; w_flush = '0; done = 1'b0; w_done = 1'b0; grant_ready = 1'b1;
      for (int s = 0; s < 2*N; s++) exp_stat[s] = 0;
      repeat (3) @(negedge clk);
      check("rst_valid", grant_valid, 0);
      check("rst_addr", grant_addr, 0);
      check("rst_len", grant_len, 0);
      check("rst_port_dir", {grant_port, grant_dir}, 0);
      check("rst_fill", fill, 0);
      check("rst_stat", stat_words[31:0], 0);
      reset = 1'b0;

      // Idle: nothing eligible, no grant.
      seen = 0;
      repeat (20) begin @(negedge clk); if (grant_valid) seen = 1; end
      check("idle_no_grant", seen, 0);

      // Full burst write then read on port 0.
      expect_grant(0, 1, 0, 0, 64);
      wr_level[0*FAW +: FAW] = 11'd200;
      serve(0, '0);
      check("fill0_after_wr", fill0(0), 64);

      expect_grant(0, 0, 0, 0, 10);
      rd_space[0*FAW +: FAW] = 11'd20;
      serve(0, '0);
      check("fill0_after_rd", fill0(0), 54);

      // One word on every write port, in port order.
      expect_grant(0, 1, 0, 64, 1);
      expect_grant(0, 1, 1, longint'(1) << RAW, 1);
      expect_grant(0, 1, 2, longint'(2) << RAW, 1);
      expect_grant(0, 1, 3, longint'(3) << RAW, 1);
      for (int p = 0; p < N; p++) wr_level[p*FAW +: FAW] = 11'd2;
      repeat (4) serve(0, '0);
      check("fill0_rr", fill0(0), 55);
      check("fill1_rr", fill0(1), 1);
      check("fill3_rr", fill0(3), 1);

      // Resume at slot 4: read of port 1 precedes the write of port 0.
      expect_grant(0, 0, 1, longint'(1) << RAW, 1);
      expect_grant(0, 1, 0, 65, 1);
      rd_space[1*FAW +: FAW] = 11'd4;
      wr_level[0*FAW +: FAW] = 11'd2;
      serve(0, '0);
      serve(0, '0);
      check("fill0_resume", fill0(0), 56);
      check("fill1_resume", fill0(1), 0);

      // Flush port 1 while busy (deferred) and port 2 (immediate).
      expect_grant(0, 1, 1, (longint'(1) << RAW) + 1, 10);
      wr_level[1*FAW +: FAW] = 11'd20;
      serve(0, 4'b0110);
      check("fill1_flushed", fill0(1), 0);
      check("fill2_flushed", fill0(2), 0);
      check("fill0_untouched", fill0(0), 56);

      expect_grant(0, 1, 1, longint'(1) << RAW, 2);
      wr_level[1*FAW +: FAW] = 11'd4;
      serve(0, '0);
      check("fill1_post_flush", fill0(1), 2);

      // rd_ptr of port 0 sits at 10.
      expect_grant(0, 0, 0, 10, 4);
      rd_space[0*FAW +: FAW] = 11'd8;
      serve(0, '0);
      check("fill0_rd2", fill0(0), 52);

      for (int s = 0; s < 2*N; s++) begin
`ifdef MEM_PORT_SCHED_STATS_EN
         check($sformatf("stat_slot%0d", s), stat_words[s*32 +: 32], exp_stat[s]);
`else
         check($sformatf("stat_slot%0d", s), stat_words[s*32 +: 32], 0);
`endif
      end

      // Small ring: pointer wrap and full-ring blocking.
      expect_grant(1, 1, 0, 0, 14);
      w_wr_level[0*FAW +: FAW] = 11'd28;
      serve(1, '0);
      check("w_fill_a", fillw(0), 14);
      expect_grant(1, 0, 0, 0, 14);
      w_rd_space[0*FAW +: FAW] = 11'd28;
      serve(1, '0);
      check("w_fill_b", fillw(0), 0);
      expect_grant(1, 1, 0, 14, 8);
      w_wr_level[0*FAW +: FAW] = 11'd16;
      serve(1, '0);
      check("w_fill_wrap", fillw(0), 8);
      expect_grant(1, 1, 0, 6, 8);
      w_wr_level[0*FAW +: FAW] = 11'd32;
      serve(1, '0);
      check("w_fill_full", fillw(0), 16);
      w_wr_level[0*FAW +: FAW] = 11'd32;
      seen = 0;
      repeat (40) begin @(negedge clk); if (w_grant_valid) seen = 1; end
      check("w_full_no_grant", seen, 0);
      w_wr_level = '0;
      expect_grant(1, 0, 0, 14, 16);
      w_rd_space[0*FAW +: FAW] = 11'd32;
      serve(1, '0);
      check("w_fill_drained", fillw(0), 0);

      // Reset in the middle of a burst abandons it.
      expect_grant(0, 1, 3, (longint'(3) << RAW) + 1, 5);
      wr_level[3*FAW +: FAW] = 11'd10;
      seen = 0;
      for (int i = 0; i < 100 && seen == 0; i++) begin
         @(negedge clk);
         if (grant_valid) seen = 1;
      end
      check("midburst_grant_seen", seen, 1);
      @(negedge clk);
      reset = 1'b1;
      wr_level = '0;
      @(negedge clk);
      check("midburst_valid", grant_valid, 0);
      check("midburst_fill0", fill0(0), 0);
      check("midburst_stat0", stat_words[31:0], 0);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
